// File: rtl/dmem_axi_wr.sv
// dmem_axi_wr: AXI4 8-beat x 64-bit INCR write-burst initiator for data-cache line evictions
// Optional feature: define DMEM_WR_EARLY_W_EN to present W beats alongside AW instead of after it.
// Ports:
//   axi_clk, axi_resetn           clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       line writeback request handshake
//   req_addr_i, req_line_i        line byte address (low 6 bits ignored), 512-bit line data
//   done_o, exc_valid_o           completion pulse, fault pulse on non-OKAY response
//   exc_code_o                    store/AMO access fault code
//   aw*, w*, b*                   AXI4 write address, data and response channels
module dmem_axi_wr #(
    parameter int ADDR_W = 32
) (
    input  logic              axi_clk,
    input  logic              axi_resetn,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [511:0]      req_line_i,
    output logic              req_ready_o,
    output logic              done_o,
    output logic              exc_valid_o,
    output logic [4:0]        exc_code_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [7:0]        awlen_o,
    output logic [2:0]        awsize_o,
    output logic [1:0]        awburst_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [63:0]       wdata_o,
    output logic [7:0]        wstrb_o,
    output logic              wlast_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [511:0]      line_q;
    logic [2:0]        beat_cnt;
    logic              aw_fin;
    logic              w_fin;
`ifdef DMEM_WR_EARLY_W_EN
    logic              aw_done;
    assign aw_fin = aw_done | (awvalid_o & awready_i);
`else
    // AW always completes in ADDR before DATA is entered
    assign aw_fin = 1'b1;
`endif
    // W side is finished once wvalid has dropped or the last beat is accepted now
    assign w_fin       = ~wvalid_o | (wready_i & wlast_o);
    assign req_ready_o = axi_resetn & (state == IDLE);
    assign awaddr_o    = addr_q;
    assign awlen_o     = 8'd7;
    assign awsize_o    = 3'b011;
    assign awburst_o   = 2'b01;
    assign wstrb_o     = 8'hFF;
    assign exc_code_o  = 5'b00111;
    assign wdata_o     = line_q[{beat_cnt, 6'b0} +: 64];
    assign wlast_o     = wvalid_o & (&beat_cnt);
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state       <= IDLE;
            addr_q      <= '0;
            line_q      <= '0;
            beat_cnt    <= '0;
            awvalid_o   <= 1'b0;
            wvalid_o    <= 1'b0;
            bready_o    <= 1'b0;
            done_o      <= 1'b0;
            exc_valid_o <= 1'b0;
`ifdef DMEM_WR_EARLY_W_EN
            aw_done     <= 1'b0;
`endif
        end else begin
            done_o      <= 1'b0;
            exc_valid_o <= 1'b0;
            case (state)
                IDLE: if (req_valid_i) begin
                    addr_q    <= req_addr_i & {{(ADDR_W-6){1'b1}}, 6'b0};
                    line_q    <= req_line_i;
                    beat_cnt  <= '0;
                    awvalid_o <= 1'b1;
`ifdef DMEM_WR_EARLY_W_EN
                    aw_done   <= 1'b0;
                    wvalid_o  <= 1'b1;
                    state     <= DATA;
`else
                    state     <= ADDR;
`endif
                end
                ADDR: if (awready_i) begin
                    awvalid_o <= 1'b0;
                    wvalid_o  <= 1'b1;
                    state     <= DATA;
                end
                DATA: begin
`ifdef DMEM_WR_EARLY_W_EN
                    if (awvalid_o && awready_i) begin
                        awvalid_o <= 1'b0;
                        aw_done   <= 1'b1;
                    end
`endif
                    if (wvalid_o && wready_i) begin
                        beat_cnt <= beat_cnt + 3'd1;
                        if (wlast_o)
                            wvalid_o <= 1'b0;
                    end
                    if (aw_fin && w_fin) begin
                        bready_o <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: if (bvalid_i) begin
                    bready_o    <= 1'b0;
                    done_o      <= 1'b1;
                    exc_valid_o <= |bresp_i;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
